// File: rtl/fp_addsub_seq.sv
// Sequential FP add/sub, one align/normalise bit per cycle; define FPADD_RNE_EN for round-to-nearest-even.
// Latency: 2 + align cycles + normalise cycles from the accept edge (+1 round, +1 more on round carry).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, then one idle bubble.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         inf,
    output logic         zero
);
`ifdef FPADD_RNE_EN
    localparam int X = 3;
`else
    localparam int X = 0;
`endif
    localparam int MW = MAN_W + 2 + X;
    localparam int HB = MAN_W + X;   // hidden-bit position; HB+1 is the carry bit
    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [EXP_W-1:0] E_ONE  = EXP_W'(1);

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
`ifdef FPADD_RNE_EN
    localparam state_t FIN = ROUND;
`else
    localparam state_t FIN = DONE;
`endif

    state_t             state, state_nx;
    logic [W-1:0]       a_r, a_nx, b_r, b_nx, res_pk;
    logic               sa, sa_nx, sb, sb_nx, spec, spec_nx, inf_nx, zero_nx;
    logic [EXP_W-1:0]   e, e_nx, d, d_nx;
    logic [MW-1:0]      ma, ma_nx, mb, mb_nx, m, m_nx, sum, mb_sh, m_rsh;
    logic               swap;
    logic [W-1:0]       big, sml;
    logic [EXP_W-1:0]   ebig, esml, ebig_eff, esml_eff;
`ifdef FPADD_RNE_EN
    logic               rnd_done, rnd_done_nx, rnd_inc;
    logic [MW-1:0]      m_rnd;
`endif

    assign swap     = b_r[W-2:0] > a_r[W-2:0];
    assign big      = swap ? b_r : a_r;
    assign sml      = swap ? a_r : b_r;
    assign ebig     = big[W-2:MAN_W];
    assign esml     = sml[W-2:MAN_W];
    assign ebig_eff = (ebig == '0) ? E_ONE : ebig;
    assign esml_eff = (esml == '0) ? E_ONE : esml;
    assign sum      = (sa == sb) ? ma + mb : ma - mb;
`ifdef FPADD_RNE_EN
    // Bit 0 is sticky: anything shifted past it stays ORed in.
    assign mb_sh    = (mb >> 1) | MW'(mb[0]);
    assign m_rsh    = (m >> 1) | MW'(m[0]);
    assign rnd_inc  = m[2] & (m[1] | m[0] | m[3]);
    assign m_rnd    = m + (rnd_inc ? MW'(8) : MW'(0));
`else
    assign mb_sh    = mb >> 1;
    assign m_rsh    = m >> 1;
`endif
    // A normalised-away hidden bit only survives at e==1, which packs as a denormal.
    assign res_pk   = {sa, (m_nx[HB] ? e_nx : {EXP_W{1'b0}}), m_nx[HB-1:X]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nx = state;
        a_nx     = a_r;
        b_nx     = b_r;
        sa_nx    = sa;
        sb_nx    = sb;
        spec_nx  = spec;
        e_nx     = e;
        d_nx     = d;
        ma_nx    = ma;
        mb_nx    = mb;
        m_nx     = m;
        inf_nx   = 1'b0;
        zero_nx  = 1'b0;
`ifdef FPADD_RNE_EN
        rnd_done_nx = rnd_done;
`endif
        case (state)
            IDLE: if (in_valid) begin
                a_nx     = a;
                b_nx     = {b[W-1] ^ op, b[W-2:0]};
`ifdef FPADD_RNE_EN
                rnd_done_nx = 1'b0;
`endif
                state_nx = UNPACK;
            end
            UNPACK: begin
                sa_nx    = big[W-1];
                sb_nx    = sml[W-1];
                e_nx     = ebig_eff;
                d_nx     = ebig_eff - esml_eff;
                ma_nx    = MW'({|ebig, big[MAN_W-1:0]}) << X;
                mb_nx    = MW'({|esml, sml[MAN_W-1:0]}) << X;
                spec_nx  = (ebig == E_ONES) || (esml == E_ONES);
                // Specials still pass through ADD so they report on the same edge as a plain add.
                state_nx = (spec_nx || d_nx == '0) ? ADD : ALIGN;
            end
            ALIGN: begin
                mb_nx = mb_sh;
                d_nx  = d - E_ONE;
                if (d_nx == '0 || mb_sh == '0) state_nx = ADD;
            end
            ADD: begin
                m_nx = sum;
                if (spec) begin
                    inf_nx   = 1'b1;
                    state_nx = DONE;
                end else if (sum == '0) begin
                    zero_nx  = 1'b1;
                    state_nx = DONE;
                end else if (sum[HB+1] || (!sum[HB] && e > E_ONE)) begin
                    state_nx = NORM;
                end else begin
                    state_nx = FIN;
                end
            end
            NORM: begin
                if (m[HB+1]) begin
                    m_nx = m_rsh;
                    e_nx = e + E_ONE;
                    if (e_nx == E_ONES) begin
                        inf_nx   = 1'b1;
                        state_nx = DONE;
                    end else begin
                        state_nx = FIN;
                    end
                end else begin
                    m_nx = m << 1;
                    e_nx = e - E_ONE;
                    if (m_nx[HB] || e_nx == E_ONE) state_nx = FIN;
                end
            end
`ifdef FPADD_RNE_EN
            ROUND: begin
                if (!rnd_done) begin
                    m_nx = m_rnd;
                    if (m_rnd[HB+1]) rnd_done_nx = 1'b1;
                    else             state_nx    = DONE;
                end else begin
                    m_nx     = m_rsh;
                    e_nx     = e + E_ONE;
                    inf_nx   = (e_nx == E_ONES);
                    state_nx = DONE;
                end
            end
`endif
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            spec   <= 1'b0;
            e      <= '0;
            d      <= '0;
            ma     <= '0;
            mb     <= '0;
            m      <= '0;
            result <= '0;
            inf    <= 1'b0;
            zero   <= 1'b0;
`ifdef FPADD_RNE_EN
            rnd_done <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            a_r   <= a_nx;
            b_r   <= b_nx;
            sa    <= sa_nx;
            sb    <= sb_nx;
            spec  <= spec_nx;
            e     <= e_nx;
            d     <= d_nx;
            ma    <= ma_nx;
            mb    <= mb_nx;
            m     <= m_nx;
`ifdef FPADD_RNE_EN
            rnd_done <= rnd_done_nx;
`endif
            if (state_nx == DONE && state != DONE) begin
                inf    <= inf_nx;
                zero   <= zero_nx;
                result <= inf_nx ? {sa, E_ONES, {MAN_W{1'b0}}} : (zero_nx ? '0 : res_pk);
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: directed vector table plus hold, bubble and mid-operation reset sequences.
module tb_fp_addsub_seq;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, op, out_valid, out_ready, inf, zero;
    logic [31:0] a, b, result;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [31:0] res_rne;
        logic        inf;
        logic        zero;
        int          lat;
        int          lat_rne;
    } vec_t;
    vec_t vecs [13];

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .inf(inf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    // Presents one operand pair and returns #1 after the accepting edge E0.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic top);
        a = ta;
        b = tb_v;
        op = top;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // lat = k when out_valid is first seen after edge E(k); gives up at 100.
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] exp_res;
        int          exp_lat;

        //            a             b             op    res           res_rne       inf   zero  lat lat_rne
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 3,  4};
        vecs[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 32'h40000000, 1'b0, 1'b0, 3,  4};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 2,  2};
        vecs[3]  = '{32'hBF800000, 32'hBF800000, 1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 2,  2};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 3,  3};
        vecs[5]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 2,  2};
        vecs[6]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 32'h3F800001, 1'b0, 1'b0, 26, 27};
        vecs[7]  = '{32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000, 32'h33800000, 1'b0, 1'b0, 26, 28};
        vecs[8]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 32'h00000002, 1'b0, 1'b0, 2,  3};
        vecs[9]  = '{32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 32'h00800000, 1'b0, 1'b0, 2,  3};
        vecs[10] = '{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 32'hBF800000, 1'b0, 1'b0, 4,  5};
        vecs[11] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 32'hBF800000, 1'b0, 1'b0, 4,  5};
        vecs[12] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 32'hFF800000, 1'b1, 1'b0, 2,  2};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'h0);
        check("reset inf", 32'(inf), 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            exp_res = vecs[i].res;
            exp_lat = vecs[i].lat;
`ifdef FPADD_RNE_EN
            exp_res = vecs[i].res_rne;
            exp_lat = vecs[i].lat_rne;
`endif
            start_op(vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("vec%0d busy in_ready", i), 32'(in_ready), 32'd0);
            wait_done(lat);
            check($sformatf("vec%0d result", i), result, exp_res);
            check($sformatf("vec%0d inf", i), 32'(inf), 32'(vecs[i].inf));
            check($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].zero));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat));
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check($sformatf("vec%0d out_valid after accept", i), 32'(out_valid), 32'd0);
            check($sformatf("vec%0d in_ready after accept", i), 32'(in_ready), 32'd1);
        end

        // DONE holds under backpressure and ignores new operands.
        start_op(32'h3F800000, 32'h3F800000, 1'b0);
        wait_done(lat);
        for (int k = 0; k < 5; k++) begin
            a = 32'h12345678 ^ 32'(k);
            b = 32'h3F800000;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d result", k), result, 32'h40000000);
            check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold release out_valid", 32'(out_valid), 32'd0);
        check("hold release in_ready", 32'(in_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("no queued op out_valid", 32'(out_valid), 32'd0);

        // Reset during ALIGN, with in_valid asserted on the reset edge.
        start_op(32'h3F800000, 32'h33C00000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("mid-op busy in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 32'h3F800000;
        b = 32'h3F800000;
        @(posedge clk);
        #1;
        check("mid-op reset out_valid", 32'(out_valid), 32'd0);
        check("mid-op reset in_ready", 32'(in_ready), 32'd1);
        check("mid-op reset result", result, 32'h0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("lost op out_valid", 32'(out_valid), 32'd0);

        start_op(32'h40400000, 32'h3F800000, 1'b1);
        wait_done(lat);
        check("recovery result", result, 32'h40000000);
`ifdef FPADD_RNE_EN
        check("recovery latency", 32'(lat), 32'd4);
`else
        check("recovery latency", 32'(lat), 32'd3);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
